// File: rtl/hash_window_feeder_pkg.sv
// Shared defaults and helpers for the hash-compute window feeder.
// The defaults mirror the engine-wide issue width, hash cover and address width.
package hash_window_feeder_pkg;

  localparam int DEF_ISSUE_W     = 16;
  localparam int DEF_COVER_BYTES = 4;
  localparam int DEF_ADDR_W      = 32;

  // A window holds one beat plus the lookahead needed by the last hash position.
  function automatic int window_bytes(input int issue_w, input int cover_bytes);
    return issue_w + cover_bytes - 1;
  endfunction

endpackage

// File: rtl/hash_window_feeder.sv
// Turns a flat byte stream into overlapping hash windows, borrowing lookahead
// bytes from the next beat and zero-padding the final window of each block.
module hash_window_feeder
  import hash_window_feeder_pkg::*;
#(
  parameter int ISSUE_W     = DEF_ISSUE_W,
  parameter int COVER_BYTES = DEF_COVER_BYTES,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  input  logic [ISSUE_W*8-1:0]                   in_data,
  input  logic                                   in_last,
  output logic                                   in_ready,
  output logic                                   output_valid,
  output logic [ADDR_W-1:0]                      output_head_addr,
  output logic [(ISSUE_W+COVER_BYTES-1)*8-1:0]   output_data,
  output logic                                   output_delim,
  input  logic                                   output_ready
);

  localparam int BEAT_W = ISSUE_W * 8;
  localparam int WIN_W  = window_bytes(ISSUE_W, COVER_BYTES) * 8;
  localparam int LA_W   = (COVER_BYTES - 1) * 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   h_data;
  logic [ADDR_W-1:0]   h_addr;
  logic [ADDR_W-1:0]   addr_cnt;

  logic                o_free;
  logic                accept;
  logic                load_cont;
  logic                load_flush;
  logic [WIN_W-1:0]    win_cont;
  logic [WIN_W-1:0]    win_flush;

  assign o_free = ~output_valid | output_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      EMPTY:   in_ready = 1'b1;
      HOLD:    in_ready = o_free;
      FLUSH:   in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign load_cont  = (state == HOLD) & accept;
  assign load_flush = (state == FLUSH) & o_free;

  // With a one-byte cover there is no lookahead and the window is the beat itself.
  generate
    if (COVER_BYTES > 1) begin : g_lookahead
      assign win_cont = {in_data[LA_W-1:0], h_data};
    end else begin : g_no_lookahead
      assign win_cont = h_data;
    end
  endgenerate

  assign win_flush = WIN_W'(h_data);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= EMPTY;
      output_valid     <= 1'b0;
      output_head_addr <= '0;
      output_delim     <= 1'b0;
      addr_cnt         <= '0;
    end else begin
      if (output_ready) output_valid <= 1'b0;
      if (accept) addr_cnt <= addr_cnt + ADDR_W'(ISSUE_W);

      unique case (state)
        EMPTY: begin
          if (accept) state <= in_last ? FLUSH : HOLD;
        end
        HOLD: begin
          // Accept here implies O is free, so the new window may overwrite it.
          if (accept) begin
            output_valid     <= 1'b1;
            output_head_addr <= h_addr;
            output_delim     <= 1'b0;
            state            <= in_last ? FLUSH : HOLD;
          end
        end
        FLUSH: begin
          if (o_free) begin
            output_valid     <= 1'b1;
            output_head_addr <= h_addr;
            output_delim     <= 1'b1;
            state            <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // NOTE: payload registers carry no reset; their contents only matter behind a valid flag.
  always_ff @(posedge clk) begin
    if (accept) begin
      h_data <= in_data;
      h_addr <= addr_cnt;
    end
    if (load_cont) begin
      output_data <= win_cont;
    end else if (load_flush) begin
      output_data <= win_flush;
    end
  end

endmodule

// File: tb/tb_hash_window_feeder.sv
// Randomised and directed bench for hash_window_feeder against a queue-based
// model that derives each expected window from the accepted byte stream.
module tb_hash_window_feeder;

  localparam int IW = 4;
  localparam int CB = 4;
  localparam int AW = 5;
  localparam int WW = (IW + CB - 1) * 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [IW*8-1:0]   in_data;
  logic              in_last;
  logic              in_ready;
  logic              output_valid;
  logic [AW-1:0]     output_head_addr;
  logic [WW-1:0]     output_data;
  logic              output_delim;
  logic              output_ready;

  hash_window_feeder #(
    .ISSUE_W    (IW),
    .COVER_BYTES(CB),
    .ADDR_W     (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .output_valid    (output_valid),
    .output_head_addr(output_head_addr),
    .output_data     (output_data),
    .output_delim    (output_delim),
    .output_ready    (output_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WW-1:0] data;
    logic [AW-1:0] addr;
    logic          delim;
    int            cyc;
  } win_t;

  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  int   irdy_low = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  win_t exp_q[$];
  win_t log_q[$];

  logic [IW*8-1:0] m_prev;
  logic [AW-1:0]   m_prev_addr;
  logic [AW-1:0]   m_addr;
  bit              m_have;
  bit              hold_pending;
  win_t            snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Each accepted beat completes the previous beat's window; a last beat also yields its padded window.
  function automatic void model_accept(input logic [IW*8-1:0] d, input logic last);
    if (m_have) exp_q.push_back('{WW'({d, m_prev}), m_prev_addr, 1'b0, 0});
    m_prev      = d;
    m_prev_addr = m_addr;
    m_addr      = m_addr + AW'(IW);
    if (last) begin
      exp_q.push_back('{WW'(d), m_prev_addr, 1'b1, 0});
      m_have = 1'b0;
    end else begin
      m_have = 1'b1;
    end
  endfunction

  always @(posedge clk) cyc++;
  always @(negedge clk) if (!in_ready) irdy_low++;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_have       = 1'b0;
      m_addr       = '0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(output_valid), 64'd1);
        check("hold_data", 64'(output_data), 64'(snap.data));
        check("hold_addr", 64'(output_head_addr), 64'(snap.addr));
        check("hold_delim", 64'(output_delim), 64'(snap.delim));
      end
      hold_pending = output_valid && !output_ready;
      snap = '{output_data, output_head_addr, output_delim, cyc};
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_window", 64'd1, 64'd0);
        end else begin
          win_t e;
          e = exp_q.pop_front();
          check("win_data", 64'(output_data), 64'(e.data));
          check("win_addr", 64'(output_head_addr), 64'(e.addr));
          check("win_delim", 64'(output_delim), 64'(e.delim));
        end
        log_q.push_back('{output_data, output_head_addr, output_delim, cyc});
      end
      if (in_valid && in_ready) model_accept(in_data, in_last);
    end
  end

  initial begin
    output_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      output_ready = 1'b1;
      else if (rdy_mode == 1) output_ready = 1'($urandom_range(0, 1));
      else                    output_ready = 1'b0;
    end
  end

  task automatic send(input logic [IW*8-1:0] d, input logic last);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_win(input string name, input int idx, input logic [AW-1:0] a,
                           input logic [WW-1:0] d, input logic dl);
    if (idx < log_q.size()) begin
      check({name, "_addr"}, 64'(log_q[idx].addr), 64'(a));
      check({name, "_data"}, 64'(log_q[idx].data), 64'(d));
      check({name, "_delim"}, 64'(log_q[idx].delim), 64'(dl));
    end else begin
      check({name, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    int base;
    int low0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    check("rst_valid", 64'(output_valid), 64'd0);
    check("rst_delim", 64'(output_delim), 64'd0);
    check("rst_addr", 64'(output_head_addr), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Two-beat block.
    base = log_q.size();
    send(32'h03020100, 1'b0);
    send(32'h07060504, 1'b1);
    wait_drain();
    check_win("t1_w0", base, 5'd0, 56'h06050403020100, 1'b0);
    check_win("t1_w1", base + 1, 5'd4, 56'h00000007060504, 1'b1);

    // Single-beat block continues the address count.
    base = log_q.size();
    low0 = irdy_low;
    send(32'hDDCCBBAA, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    wait_drain();
    check_win("t2_w0", base, 5'd8, 56'h000000DDCCBBAA, 1'b1);
    check("t2_count", 64'(log_q.size() - base), 64'd1);
    check("t2_in_ready_low", 64'(irdy_low - low0), 64'd1);

    // Continuous eight-beat block from a fresh address counter.
    do_reset();
    base = log_q.size();
    low0 = irdy_low;
    for (int i = 0; i < 8; i++) send(32'($urandom), i == 7);
    repeat (4) @(posedge clk);
    #1;
    wait_drain();
    check("t3_count", 64'(log_q.size() - base), 64'd8);
    check("t3_in_ready_low", 64'(irdy_low - low0), 64'd1);
    if (log_q.size() >= base + 8) begin
      check("t3_span", 64'(log_q[base+7].cyc - log_q[base].cyc), 64'd7);
      for (int i = 0; i < 8; i++) check("t3_addr", 64'(log_q[base+i].addr), 64'(i * 4));
    end

    // Address counter wraps to zero after 32 bytes.
    base = log_q.size();
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b1);
    wait_drain();
    check_win("t4_w0", base, 5'd0, 56'h22222211111111, 1'b0);
    check_win("t4_w1", base + 1, 5'd4, 56'h00000022222222, 1'b1);

    // Downstream stall mid-block.
    base = log_q.size();
    send(32'hA0A0A0A0, 1'b0);
    send(32'hA1A1A1A1, 1'b0);
    send(32'hA2A2A2A2, 1'b0);
    #1;
    rdy_mode = 2;
    fork
      begin
        send(32'hA3A3A3A3, 1'b0);
        send(32'hA4A4A4A4, 1'b0);
        send(32'hA5A5A5A5, 1'b1);
      end
      begin
        repeat (3) @(negedge clk);
        check("t5_stall_valid", 64'(output_valid), 64'd1);
        check("t5_stall_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rdy_mode = 0;
      end
    join
    wait_drain();
    check("t5_count", 64'(log_q.size() - base), 64'd6);

    // Reset while a beat is held and a window is pending.
    send(32'hB0B0B0B0, 1'b0);
    send(32'hB1B1B1B1, 1'b0);
    check("t6_pre_valid", 64'(output_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 64'(output_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = log_q.size();
    send(32'hC0C1C2C3, 1'b1);
    wait_drain();
    check_win("t6_w0", base, 5'd0, 56'h000000C0C1C2C3, 1'b1);
    check("t6_count", 64'(log_q.size() - base), 64'd1);

    // Random blocks, gaps and backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 80; i++) begin
      send(32'($urandom), ($urandom_range(0, 3) == 0) || (i == 79));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    wait_drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("final_idle_valid", 64'(output_valid), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hash_window_feeder.md
Name: hash_window_feeder

Overview:
- Producer side of the hash-compute input interface.
- Accepts a flat byte stream of ISSUE_W bytes per beat and emits overlapping windows of ISSUE_W+COVER_BYTES-1 bytes, each tagged with its head address and a block delimiter, as the hash-compute input expects.
- Borrows COVER_BYTES-1 lookahead bytes from the next beat. At block end the tail is zero-padded and the window is marked with delim.
- Sits between the input byte buffer and the hash-compute stage of the hash engine.

Parameters:
ISSUE_W, 16 (`HASH_ISSUE_WIDTH), bytes per beat / hash positions per window
COVER_BYTES, 4 (`HASH_COVER_BYTES), bytes covered by one hash; legal range 1..8, and COVER_BYTES-1 <= ISSUE_W
ADDR_W, 32 (`ADDR_WIDTH), head address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_data  in  ISSUE_W*8  byte i at [i*8+:8] is stream byte base+i
in_last  in  1  beat is last of a block
in_ready  out  1  beat accepted when in_valid&&in_ready
output_valid  out  1  window valid
output_head_addr  out  ADDR_W  address of window byte 0
output_data  out  (ISSUE_W+COVER_BYTES-1)*8  window; byte j at [j*8+:8]
output_delim  out  1  final window of block
output_ready  in  1  downstream accept

Behaviour:
- Reset is asynchronous, active-low, on clk. Cleared: state=EMPTY, output_valid=0, addr_cnt=0, output_delim=0, output_head_addr=0. Data registers are not reset; output_data is don't-care while invalid.
- Internal hold register H: {data ISSUE_W bytes, addr}. Output register O: {data, addr, delim}.
- o_free = ~output_valid | output_ready.
- States:
  - EMPTY: in_ready=1. On accept: H<=in_data, H.addr<=addr_cnt, addr_cnt<=addr_cnt+ISSUE_W (wraps mod 2^ADDR_W). Go to FLUSH if in_last, else HOLD.
  - HOLD: in_ready=o_free. On accept: O<={in_data[(COVER_BYTES-1)*8-1:0], H.data}, O.addr<=H.addr, O.delim<=0, output_valid<=1. Then H<=in beat, H.addr<=addr_cnt, addr_cnt+=ISSUE_W. Go to FLUSH if in_last, else stay in HOLD. If no accept and o_free with output_ready: output_valid<=0.
  - FLUSH: in_ready=0. When o_free: O<={(COVER_BYTES-1) zero bytes, H.data}, O.addr<=H.addr, O.delim<=1, output_valid<=1; go to EMPTY.
- O is held stable while output_valid && ~output_ready (no payload change, no drop).
- Throughput: 1 beat/cycle steady state within a block. One bubble cycle per block end (FLUSH).
- Latency:
  - A non-last beat's window is visible the cycle after the following beat is accepted.
  - A last beat's window is visible two edges after its acceptance, provided O is free.
- addr_cnt continues across blocks and is never cleared except by reset.
- COVER_BYTES=1: the lookahead slice is empty; the window equals the beat; FLUSH still emits with delim=1.
- Single-beat block (in_last on first beat): EMPTY->FLUSH, exactly one window, delim=1.
- Reset mid-block: any held beat and any pending O are discarded, output_valid drops asynchronously, and the next accepted beat gets addr 0.

Decomposition:
- Width macros come from the shared parameters.vh: ISSUE_W, COVER_BYTES, ADDR_W, and the derived window width (ISSUE_W+COVER_BYTES-1)*8.
- The state encoding (EMPTY/HOLD/FLUSH) is local localparams.
- No sub-module. The output register is inline because the existing forward register uses synchronous reset.

Test Plan:
- Params ISSUE_W=4, COVER_BYTES=4; two beats 32'h03020100, then 32'h07060504 with last -> out {addr 0, data 56'h06050403020100, delim 0}, then {addr 4, data 56'h00000007060504, delim 1}.
- Single last beat 32'hDDCCBBAA after the previous test -> one window {addr 8, 56'h000000DDCCBBAA, delim 1}; in_ready low exactly one cycle (FLUSH).
- Continuous 8-beat block with output_ready=1 -> 8 windows, addrs 0,4,...,28, one per cycle after the first, in_ready high except the FLUSH cycle.
- output_ready held 0 for 5 cycles mid-block -> O stable, in_ready=0 in HOLD, no beat lost or duplicated; windows resume in order on release.
- rst_n asserted while state=HOLD with output_valid=1 -> output_valid=0 immediately (async). After release, the next beat gets addr 0 and the prior held beat is never emitted.
- Address wrap (ADDR_W=4, ISSUE_W=4): beats at addrs 8 and 12, then the next beat -> head_addr 0.
